// File: rtl/timer_master_ctrl_if.sv
// Command/response and Avalon-MM s1 bundle between the timer sequencer and its neighbours.
// Ports: cmd_* / rsp_* / tick / event_count toward the control FSM; av_* toward the timer slave.
// master modport = sequencer side, slave modport = controller + timer side.
interface timer_master_ctrl_if #(
  parameter int EVT_W = 16
);
  // command / response side
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [31:0]      cmd_period;
  logic             cmd_continuous;
  logic             cmd_irq_en;
  logic             rsp_valid;
  logic [31:0]      rsp_data;
  logic             tick;
  logic [EVT_W-1:0] event_count;
  // Avalon-MM side
  logic [2:0]       av_address;
  logic             av_chipselect;
  logic             av_write_n;
  logic [15:0]      av_writedata;
  logic [15:0]      av_readdata;
  logic             av_irq;

  modport master (
    input  cmd_valid, cmd_op, cmd_period, cmd_continuous, cmd_irq_en,
    input  av_readdata, av_irq,
    output cmd_ready, rsp_valid, rsp_data, tick, event_count,
    output av_address, av_chipselect, av_write_n, av_writedata
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_period, cmd_continuous, cmd_irq_en,
    output av_readdata, av_irq,
    input  cmd_ready, rsp_valid, rsp_data, tick, event_count,
    input  av_address, av_chipselect, av_write_n, av_writedata
  );
endinterface

// File: rtl/timer_master_ctrl.sv
// Avalon-MM master that expands timer commands into s1 register writes/reads and services the timer irq.
// Latency accept->rsp_valid: CONFIG 4, STOP 2, SNAPSHOT 6, STATUS 3 cycles; irq service emits tick 2 cycles after pickup.
// Backpressure: cmd_ready only in IDLE with no pending irq (irq wins); ports: i_clk, i_reset_n, bus (master modport).
module timer_master_ctrl #(
  parameter bit IRQ_AUTO_ACK = 1'b1,
  parameter int EVT_W        = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  timer_master_ctrl_if.master   bus
);

  // Timer slave register map
  localparam logic [2:0] A_STATUS  = 3'd0;
  localparam logic [2:0] A_CONTROL = 3'd1;
  localparam logic [2:0] A_PERIODL = 3'd2;
  localparam logic [2:0] A_PERIODH = 3'd3;
  localparam logic [2:0] A_SNAPL   = 3'd4;
  localparam logic [2:0] A_SNAPH   = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_PL, S_WR_PH, S_WR_CTRL, S_WR_STOP, S_WR_SNAP,
    S_RA_SL, S_RD_SL, S_RA_SH, S_RD_SH, S_RA_ST, S_RD_ST, S_ACK, S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [15:0]      r_period_h;
  logic             r_cont;
  logic             r_irq_en;
  logic [15:0]      r_snap_l;

  logic [2:0]       r_av_address;
  logic             r_av_chipselect;
  logic             r_av_write_n;
  logic [15:0]      r_av_writedata;
  logic             r_rsp_valid;
  logic [31:0]      r_rsp_data;
  logic             r_tick;
  logic [EVT_W-1:0] r_event_count;

  logic [2:0]       w_addr;
  logic             w_cs;
  logic             w_wn;
  logic [15:0]      w_wdata;
  logic [31:0]      w_rsp_data;
  logic             w_irq_take;
  logic             w_accept;
  logic             w_to_done;

  assign w_irq_take    = IRQ_AUTO_ACK && bus.av_irq;
  assign bus.cmd_ready = (r_state == S_IDLE) && !w_irq_take;
  assign w_accept      = bus.cmd_valid && bus.cmd_ready;
  assign w_to_done     = (w_next == S_DONE);

  assign bus.av_address    = r_av_address;
  assign bus.av_chipselect = r_av_chipselect;
  assign bus.av_write_n    = r_av_write_n;
  assign bus.av_writedata  = r_av_writedata;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_data      = r_rsp_data;
  assign bus.tick          = r_tick;
  assign bus.event_count   = r_event_count;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state plus the bus/response values for the state being entered.
  // Every output is registered from these, so the bus reflects r_state with no decode glitches.
  always_comb begin
    w_next     = r_state;
    w_cs       = 1'b0;
    w_wn       = 1'b1;
    w_addr     = 3'd0;
    w_wdata    = 16'h0000;
    w_rsp_data = 32'h0;

    unique case (r_state)
      S_IDLE: begin
        if (w_irq_take) begin
          w_next = S_ACK;
        end else if (bus.cmd_valid) begin
          unique case (bus.cmd_op)
            2'd0: w_next = S_WR_PL;
            2'd1: w_next = S_WR_STOP;
            2'd2: w_next = S_WR_SNAP;
            2'd3: w_next = S_RA_ST;
          endcase
        end
      end
      S_WR_PL:   w_next = S_WR_PH;
      S_WR_PH:   w_next = S_WR_CTRL;
      S_WR_CTRL: w_next = S_DONE;
      S_WR_STOP: w_next = S_DONE;
      S_WR_SNAP: w_next = S_RA_SL;
      S_RA_SL:   w_next = S_RD_SL;
      S_RD_SL:   w_next = S_RA_SH;
      S_RA_SH:   w_next = S_RD_SH;
      S_RD_SH:   w_next = S_DONE;
      S_RA_ST:   w_next = S_RD_ST;
      S_RD_ST:   w_next = S_DONE;
      S_ACK:     w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase

    unique case (w_next)
      S_WR_PL: begin
        // Entered only from IDLE on accept, so the low period half comes straight off the command.
        w_cs    = 1'b1;
        w_wn    = 1'b0;
        w_addr  = A_PERIODL;
        w_wdata = bus.cmd_period[15:0];
      end
      S_WR_PH: begin
        w_cs    = 1'b1;
        w_wn    = 1'b0;
        w_addr  = A_PERIODH;
        w_wdata = r_period_h;
      end
      S_WR_CTRL: begin
        // START plus CONT/ITO; START beats the slave's reload-induced stop in this cycle.
        w_cs    = 1'b1;
        w_wn    = 1'b0;
        w_addr  = A_CONTROL;
        w_wdata = {12'h000, 2'b01, r_cont, r_irq_en};
      end
      S_WR_STOP: begin
        w_cs    = 1'b1;
        w_wn    = 1'b0;
        w_addr  = A_CONTROL;
        w_wdata = 16'h0008;
      end
      S_WR_SNAP: begin
        w_cs    = 1'b1;
        w_wn    = 1'b0;
        w_addr  = A_SNAPL;
      end
      S_RA_SL: begin
        w_cs   = 1'b1;
        w_addr = A_SNAPL;
      end
      S_RD_SL: w_addr = A_SNAPL;
      S_RA_SH: begin
        w_cs   = 1'b1;
        w_addr = A_SNAPH;
      end
      S_RD_SH: w_addr = A_SNAPH;
      S_RA_ST: begin
        w_cs   = 1'b1;
        w_addr = A_STATUS;
      end
      S_RD_ST: w_addr = A_STATUS;
      S_ACK: begin
        // Writing status clears TO, which drops the slave irq the next cycle.
        w_cs   = 1'b1;
        w_wn   = 1'b0;
        w_addr = A_STATUS;
      end
      default: begin
        w_cs = 1'b0;
        w_wn = 1'b1;
      end
    endcase

    // Slave readdata is valid during the RD state, so the response is built as DONE is entered.
    if (w_to_done) begin
      unique case (r_state)
        S_RD_SH: w_rsp_data = {bus.av_readdata, r_snap_l};
        S_RD_ST: w_rsp_data = {30'b0, bus.av_readdata[1:0]};
        default: w_rsp_data = 32'h0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_period_h      <= 16'h0000;
      r_cont          <= 1'b0;
      r_irq_en        <= 1'b0;
      r_snap_l        <= 16'h0000;
      r_av_address    <= 3'd0;
      r_av_chipselect <= 1'b0;
      r_av_write_n    <= 1'b1;
      r_av_writedata  <= 16'h0000;
      r_rsp_valid     <= 1'b0;
      r_rsp_data      <= 32'h0;
      r_tick          <= 1'b0;
      r_event_count   <= '0;
    end else begin
      if (w_accept) begin
        r_period_h <= bus.cmd_period[31:16];
        r_cont     <= bus.cmd_continuous;
        r_irq_en   <= bus.cmd_irq_en;
      end
      if (r_state == S_RD_SL) begin
        r_snap_l <= bus.av_readdata;
      end
      r_av_address    <= w_addr;
      r_av_chipselect <= w_cs;
      r_av_write_n    <= w_wn;
      r_av_writedata  <= w_wdata;
      // DONE after ACK signals a serviced timeout instead of a command completion.
      r_rsp_valid     <= w_to_done && (r_state != S_ACK);
      r_rsp_data      <= w_rsp_data;
      r_tick          <= w_to_done && (r_state == S_ACK);
      if (w_to_done && (r_state == S_ACK)) begin
        r_event_count <= r_event_count + EVT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_timer_master_ctrl.sv
// Directed bench for timer_master_ctrl with a behavioural interval-timer slave on s1.
// Inputs driven and outputs sampled on the falling edge; DUT registers on the rising edge.
// EVT_W=4 so event_count wrap is reachable in a short run.
module tb_timer_master_ctrl;

  logic clk;
  logic reset_n;

  timer_master_ctrl_if #(.EVT_W(4)) bus ();

  timer_master_ctrl #(.IRQ_AUTO_ACK(1'b1), .EVT_W(4)) dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- interval timer slave model ----------------
  logic [15:0] m_pl, m_ph, m_rdata;
  logic        m_cont, m_ito, m_run, m_to;
  logic [31:0] m_cnt, m_snap;
  logic        tb_load;
  logic [31:0] tb_load_val;

  assign bus.av_readdata = m_rdata;
  assign bus.av_irq      = m_to & m_ito;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pl <= 16'h0; m_ph <= 16'h0; m_rdata <= 16'h0;
      m_cont <= 1'b0; m_ito <= 1'b0; m_run <= 1'b0; m_to <= 1'b0;
      m_cnt <= 32'h0; m_snap <= 32'h0;
    end else begin
      if (m_run) begin
        if (m_cnt == 32'h0) begin
          m_to  <= 1'b1;
          m_cnt <= {m_ph, m_pl};
          if (!m_cont) m_run <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 32'd1;
        end
      end
      if (tb_load) m_cnt <= tb_load_val;
      if (bus.av_chipselect && bus.av_write_n) begin
        case (bus.av_address)
          3'd0:    m_rdata <= {14'b0, m_run, m_to};
          3'd1:    m_rdata <= {14'b0, m_cont, m_ito};
          3'd2:    m_rdata <= m_pl;
          3'd3:    m_rdata <= m_ph;
          3'd4:    m_rdata <= m_snap[15:0];
          3'd5:    m_rdata <= m_snap[31:16];
          default: m_rdata <= 16'h0;
        endcase
      end
      if (bus.av_chipselect && !bus.av_write_n) begin
        case (bus.av_address)
          3'd0: m_to <= 1'b0;
          3'd1: begin
            m_ito  <= bus.av_writedata[0];
            m_cont <= bus.av_writedata[1];
            if (bus.av_writedata[2]) begin
              m_run <= 1'b1;
              m_cnt <= {m_ph, m_pl};
            end else if (bus.av_writedata[3]) begin
              m_run <= 1'b0;
            end
          end
          3'd2: m_pl <= bus.av_writedata;
          3'd3: m_ph <= bus.av_writedata;
          3'd4, 3'd5: m_snap <= m_cnt;
          default: ;
        endcase
      end
    end
  end

  // ---------------- checking helpers ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // {cs, write_n, address, writedata}
  function automatic logic [31:0] wrv();
    return {11'b0, bus.av_chipselect, bus.av_write_n, bus.av_address, bus.av_writedata};
  endfunction

  // {cs, write_n, address}
  function automatic logic [31:0] rav();
    return {27'b0, bus.av_chipselect, bus.av_write_n, bus.av_address};
  endfunction

  // {write_n, address} -- read-data cycle, chipselect not checked
  function automatic logic [31:0] rdv();
    return {28'b0, bus.av_write_n, bus.av_address};
  endfunction

  // Advance to the next tick; n = falling edges taken (bounded).
  task automatic next_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.tick !== 1'b1 && n < 400);
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] per, input logic cont, input logic ien);
    bus.cmd_valid      = 1'b1;
    bus.cmd_op         = op;
    bus.cmd_period     = per;
    bus.cmd_continuous = cont;
    bus.cmd_irq_en     = ien;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int rv_cnt;

    reset_n = 1'b0;
    tb_load = 1'b0;
    tb_load_val = 32'h0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'd0;
    bus.cmd_period = 32'h0;
    bus.cmd_continuous = 1'b0;
    bus.cmd_irq_en = 1'b0;

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_bus",   wrv(), {11'b0, 1'b0, 1'b1, 3'd0, 16'h0000});
    chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_evt",   32'(bus.event_count), 32'd0);
    chk("rst_rsp",   {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_tick",  {31'b0, bus.tick}, 32'd0);

    // CONFIG period=99 cont=1 irq_en=1
    issue(2'd0, 32'd99, 1'b1, 1'b1);
    chk("cfg_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk); bus.cmd_valid = 1'b0;
    chk("cfg_wr_pl", wrv(), {11'b0, 1'b1, 1'b0, 3'd2, 16'h0063});
    @(negedge clk);
    chk("cfg_wr_ph", wrv(), {11'b0, 1'b1, 1'b0, 3'd3, 16'h0000});
    @(negedge clk);
    chk("cfg_wr_ctl", wrv(), {11'b0, 1'b1, 1'b0, 3'd1, 16'h0007});
    chk("cfg_no_rsp3", {31'b0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    chk("cfg_rsp4", {31'b0, bus.rsp_valid}, 32'd1);
    chk("cfg_rsp_data", bus.rsp_data, 32'd0);
    chk("cfg_bus_idle", rav(), {27'b0, 1'b0, 1'b1, 3'd0});
    @(negedge clk);
    chk("cfg_rsp_pulse", {31'b0, bus.rsp_valid}, 32'd0);

    // Periodic ticks every 100 cycles, event_count 1,2,3
    next_tick(n);
    chk("tick1_seen", {31'b0, bus.tick}, 32'd1);
    chk("tick1_evt", 32'(bus.event_count), 32'd1);
    next_tick(n);
    chk("tick2_ival", 32'(n), 32'd100);
    chk("tick2_evt", 32'(bus.event_count), 32'd2);
    next_tick(n);
    chk("tick3_ival", 32'(n), 32'd100);
    chk("tick3_evt", 32'(bus.event_count), 32'd3);

    // irq and cmd_valid together in IDLE: irq serviced first
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.av_irq !== 1'b1 && n < 200);
    chk("irq_seen", {31'b0, bus.av_irq}, 32'd1);
    issue(2'd3, 32'd0, 1'b0, 1'b0);
    chk("irq_ready_low", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    chk("ack_write", wrv(), {11'b0, 1'b1, 1'b0, 3'd0, 16'h0000});
    chk("ack_ready_low", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    chk("ack_tick", {31'b0, bus.tick}, 32'd1);
    chk("ack_evt", 32'(bus.event_count), 32'd4);
    chk("ack_no_rsp", {31'b0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    chk("ack_tick_pulse", {31'b0, bus.tick}, 32'd0);
    chk("post_ack_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk); bus.cmd_valid = 1'b0;
    chk("st_ra", rav(), {27'b0, 1'b1, 1'b1, 3'd0});
    @(negedge clk);
    chk("st_rd", rdv(), {28'b0, 1'b1, 3'd0});
    @(negedge clk);
    chk("st_rsp3", {31'b0, bus.rsp_valid}, 32'd1);
    chk("st_running", bus.rsp_data, 32'h0000_0002);

    // STOP then STATUS
    @(negedge clk);
    issue(2'd1, 32'd0, 1'b0, 1'b0);
    chk("stop_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk); bus.cmd_valid = 1'b0;
    chk("stop_write", wrv(), {11'b0, 1'b1, 1'b0, 3'd1, 16'h0008});
    @(negedge clk);
    chk("stop_rsp2", {31'b0, bus.rsp_valid}, 32'd1);
    @(negedge clk);
    issue(2'd3, 32'd0, 1'b0, 1'b0);
    @(negedge clk); bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("st2_rsp", {31'b0, bus.rsp_valid}, 32'd1);
    chk("st2_stopped", bus.rsp_data, 32'h0000_0000);

    // SNAPSHOT with counter forced to 0x0001_2345 (timer stopped)
    tb_load = 1'b1; tb_load_val = 32'h0001_2345;
    @(negedge clk);
    tb_load = 1'b0;
    issue(2'd2, 32'd0, 1'b0, 1'b0);
    @(negedge clk); bus.cmd_valid = 1'b0;
    chk("snap_wr", wrv(), {11'b0, 1'b1, 1'b0, 3'd4, 16'h0000});
    @(negedge clk);
    chk("snap_ra_l", rav(), {27'b0, 1'b1, 1'b1, 3'd4});
    @(negedge clk);
    chk("snap_rd_l", rdv(), {28'b0, 1'b1, 3'd4});
    @(negedge clk);
    chk("snap_ra_h", rav(), {27'b0, 1'b1, 1'b1, 3'd5});
    @(negedge clk);
    chk("snap_rd_h", rdv(), {28'b0, 1'b1, 3'd5});
    chk("snap_no_rsp5", {31'b0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    chk("snap_rsp6", {31'b0, bus.rsp_valid}, 32'd1);
    chk("snap_data", bus.rsp_data, 32'h0001_2345);

    // Reset during RD_SL of a SNAPSHOT
    @(negedge clk);
    issue(2'd2, 32'd0, 1'b0, 1'b0);
    @(negedge clk); bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rd_sl", rdv(), {28'b0, 1'b1, 3'd4});
    reset_n = 1'b0;
    #1;
    chk("mid_rst_bus", wrv(), {11'b0, 1'b0, 1'b1, 3'd0, 16'h0000});
    chk("mid_rst_evt", 32'(bus.event_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rv_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) rv_cnt++;
    end
    chk("mid_no_rsp", 32'(rv_cnt), 32'd0);
    chk("mid_ready", 32'(bus.cmd_ready), 32'd1);

    // event_count wrap: 16 timeouts at period 9 (every 10 cycles)
    issue(2'd0, 32'd9, 1'b1, 1'b1);
    @(negedge clk); bus.cmd_valid = 1'b0;
    chk("wcfg_wr_pl", wrv(), {11'b0, 1'b1, 1'b0, 3'd2, 16'h0009});
    for (int i = 1; i <= 16; i++) begin
      next_tick(n);
      chk("wrap_tick", {31'b0, bus.tick}, 32'd1);
      chk("wrap_evt", 32'(bus.event_count), 32'(i % 16));
      if (i > 1) chk("wrap_ival", 32'(n), 32'd10);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_master_ctrl.md
Name: timer_master_ctrl

Overview:
- Avalon-MM master sequencer that drives the 16-bit register interface of the system interval-timer slave.
- Accepts high-level commands (configure+start, stop, snapshot, status read) and expands them into slave register writes and reads.
- Services the timer irq by clearing status and emitting a tick pulse plus a running event count.
- Sits between a hardware control FSM and the timer slave s1 port, replacing software timer drivers.

Parameters:
- IRQ_AUTO_ACK, 1, 1 = service irq in hardware (clear status, pulse tick); 0 = ignore irq.
- EVT_W, 16, width of event_count.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
- cmd_op  in  2  0=CONFIG, 1=STOP, 2=SNAPSHOT, 3=STATUS
- cmd_period  in  32  period for CONFIG
- cmd_continuous  in  1  CONT bit for CONFIG
- cmd_irq_en  in  1  ITO bit for CONFIG
- rsp_valid  out  1  one-cycle pulse, command complete
- rsp_data  out  32  SNAPSHOT: counter value; STATUS: {30'b0,run,to}; else 0
- tick  out  1  one-cycle pulse per serviced timeout
- event_count  out  EVT_W  serviced timeouts, wraps
- av_address  out  3  slave register index
- av_chipselect  out  1  slave select
- av_write_n  out  1  active-low write
- av_writedata  out  16  write data
- av_readdata  in  16  slave read data, registered in slave (1-cycle latency)
- av_irq  in  1  timer interrupt

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low.
- Outputs under reset: state IDLE; av_chipselect=0, av_write_n=1, av_address=0, av_writedata=0; rsp_valid=0, rsp_data=0, tick=0, event_count=0.
- All av_* and rsp/tick outputs are registered.
- Write transfer: one cycle with chipselect=1, write_n=0. No waitrequest.
- Read transfer uses two states:
  - RA: address driven, chipselect=1, write_n=1.
  - RD: address held, av_readdata sampled at the end of RD.
- cmd_ready = (state==IDLE) && !(IRQ_AUTO_ACK && av_irq). cmd_ready is combinational. The irq has priority when both the irq and cmd_valid are pending in IDLE.
- Command fields are latched on acceptance.
- FSM states: IDLE, WR_PL, WR_PH, WR_CTRL, WR_STOP, WR_SNAP, RA_SL, RD_SL, RA_SH, RD_SH, RA_ST, RD_ST, ACK, DONE.
- CONFIG: WR_PL (addr2, period[15:0]) -> WR_PH (addr3, period[31:16]) -> WR_CTRL (addr1, data 16'h0004|{cont,irq_en}) -> DONE.
  - The slave's force_reload lands in the WR_CTRL cycle.
  - In that cycle the start strobe wins over the stop strobe, so the timer runs.
- STOP: WR_STOP (addr1, data 16'h0008) -> DONE. This clears CONT/ITO.
- SNAPSHOT: WR_SNAP (addr4, data 0) -> RA_SL (addr4) -> RD_SL -> RA_SH (addr5) -> RD_SH -> DONE.
  - rsp_data = {snap_h, snap_l}.
- STATUS: RA_ST (addr0) -> RD_ST -> DONE. rsp_data = {30'b0, readdata[1:0]}.
- ACK: entered from IDLE when IRQ_AUTO_ACK && av_irq.
  - Writes addr0, data 0, which clears the timeout.
  - Then DONE-like return to IDLE with tick=1 for exactly one cycle and event_count+1 (wraps from all-ones to 0).
  - ACK does not assert rsp_valid.
- DONE: rsp_valid=1 for one cycle, bus idle, then IDLE.
- Bus idle value: chipselect=0, write_n=1.
- Latencies from the accept edge to the rsp_valid cycle:
  - CONFIG 4 cycles
  - STOP 2 cycles
  - SNAPSHOT 6 cycles
  - STATUS 3 cycles
- IRQ re-check: av_irq is sampled only in IDLE. An irq asserting mid-command is serviced after DONE.
  - The slave irq deasserts the cycle after the ACK write, so ACK is entered only once per timeout.
- Reset mid-command: bus returns to idle immediately, the command is dropped, and no rsp_valid is produced.
- cmd_op values are fully decoded. No illegal op exists.

Test Plan:
- Reset release, no commands:
  - av_chipselect=0, av_write_n=1, cmd_ready=1, event_count=0.
- CONFIG period=32'd99, cont=1, irq_en=1:
  - Write sequence (addr2,0x0063), (addr3,0x0000), (addr1,0x0007) on consecutive cycles.
  - rsp_valid 4 cycles after accept.
  - With the slave model attached, tick pulses every 100 cycles and event_count counts 1,2,3.
- SNAPSHOT with the slave counter at 0x0001_2345:
  - Write addr4, read addr4 then addr5.
  - rsp_data=32'h0001_2345, rsp_valid 6 cycles after accept.
- av_irq high together with cmd_valid in IDLE:
  - cmd_ready=0, ACK write (addr0,0) issued first.
  - tick=1, then the command is accepted on the next IDLE cycle.
- STOP during a running timer, then STATUS:
  - Write (addr1,0x0008), then STATUS returns rsp_data[1]=0.
- Reset mid-SNAPSHOT (during RD_SL), and event_count wrap:
  - Reset during RD_SL: bus idle at once, no rsp_valid after release.
  - With EVT_W=4, 16 serviced timeouts: event_count wraps to 0.
